// File: rtl/muxn_pipe_if.sv
// Request/response bundle for muxn_pipe: flattened input bus, select,
// valid/ready on both sides, and the bad-select error reporting signals.
interface muxn_pipe_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned ERRCNT_W = 8
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_pulse;
  logic                    err_flag;
  logic [ERRCNT_W-1:0]     err_count;
  logic                    err_clr;

  modport master (
    output in_data, in_sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_sel, out_valid, err_pulse, err_flag, err_count
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_sel, out_valid, err_pulse, err_flag, err_count
  );
endinterface

// File: rtl/muxn_pipe.sv
// N:1 datapath mux with registered output, 2-entry skid buffer for
// backpressure without combinational ready, and bad-select error tracking.
module muxn_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  muxn_pipe_if.slave     bus
);

  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    skid_data_q, skid_data_d;
  logic [SEL_W-1:0]    skid_sel_q,  skid_sel_d;
  logic                skid_valid_q, skid_valid_d;
  logic                in_ready_q,  in_ready_d;
  logic                err_pulse_q, err_pulse_d;
  logic                err_flag_q,  err_flag_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0]    sel_data;
  logic                sel_bad;
  logic                accept;
  logic                load_out;

  // Decode the select; unmatched (out-of-range) selects yield zero data.
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_valid_d = skid_valid_q;
    err_flag_d   = err_flag_q;
    err_count_d  = err_count_q;

    accept   = bus.in_valid && in_ready_q;
    load_out = !out_valid_q || bus.out_ready;

    // Skid entry always takes priority so ordering stays FIFO.
    if (load_out) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_sel_d    = skid_sel_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = sel_data;
        out_sel_d   = bus.in_sel;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = sel_data;
      skid_sel_d   = bus.in_sel;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;

    // A coincident error beats err_clr: flag set, count restarts at one.
    err_pulse_d = accept && sel_bad;
    if (err_pulse_d) begin
      err_flag_d = 1'b1;
      if (bus.err_clr) begin
        err_count_d = ERRCNT_W'(1);
      end else if (err_count_q != {ERRCNT_W{1'b1}}) begin
        err_count_d = err_count_q + ERRCNT_W'(1);
      end
    end else if (bus.err_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      err_pulse_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      err_pulse_q  <= err_pulse_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_count = err_count_q;

endmodule
